// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: turns execute-stage results into data-memory
// loads/stores over a req/ack bus and hands a single-pulse result to writeback.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ICONT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_in,
  input  logic [31:0]        result_in,
  input  logic [31:0]        hold_op2_in,
  input  logic [ICONT_W-1:0] iCont_in,
  input  logic [31:0]        PC_in,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [1:0]         mem_size,
  input  logic               mem_unsigned,
  output logic               stall_out,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [31:0]        dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic [31:0]        wb_data,
  output logic [ICONT_W-1:0] iCont_out,
  output logic [31:0]        PC_out,
  output logic               misalign,
  output logic               bus_err,
  output logic               done_out
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        pcPend_q, pcPend_d;
  logic [ICONT_W-1:0] icPend_q, icPend_d;
  logic [31:0]        wb_q, wb_d;
  logic [31:0]        pcOut_q, pcOut_d;
  logic [ICONT_W-1:0] icOut_q, icOut_d;
  logic               mis_q, mis_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic               isMem, misAligned;
  logic [3:0]         laneBe;
  logic [31:0]        laneData;

  // Size 11 behaves exactly like a word access (size[1] set).
  function automatic logic [31:0] extractLoad(input logic [31:0] rd, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    if (sz[1])           extractLoad = rd;
    else if (sz == 2'b01) extractLoad = {{16{h[15] & ~uns}}, h};
    else                 extractLoad = {{24{b[7] & ~uns}}, b};
  endfunction

  always_comb begin
    isMem      = mem_read | mem_write;
    misAligned = ((mem_size == 2'b01) && result_in[0]) ||
                 (mem_size[1] && (result_in[1:0] != 2'b00));
    laneBe     = 4'b1111;
    laneData   = hold_op2_in;
    if (mem_size == 2'b00) begin
      laneBe   = 4'b0001 << result_in[1:0];
      laneData = {4{hold_op2_in[7:0]}};
    end else if (mem_size == 2'b01) begin
      laneBe   = result_in[1] ? 4'b1100 : 4'b0011;
      laneData = {2{hold_op2_in[15:0]}};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    pcPend_d = pcPend_q;
    icPend_d = icPend_q;
    wb_d     = wb_q;
    pcOut_d  = pcOut_q;
    icOut_d  = icOut_q;
    mis_d    = mis_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_in) begin
          if (!isMem || misAligned) begin
            done_d  = 1'b1;
            wb_d    = isMem ? 32'd0 : result_in;
            mis_d   = isMem;
            err_d   = 1'b0;
            pcOut_d = PC_in;
            icOut_d = iCont_in;
          end else begin
            state_d  = REQ;
            cnt_d    = 8'd0;
            we_d     = mem_write;
            addr_d   = {result_in[31:2], 2'b00};
            off_d    = result_in[1:0];
            size_d   = mem_size;
            uns_d    = mem_unsigned;
            be_d     = laneBe;
            wdata_d  = laneData;
            pcPend_d = PC_in;
            icPend_d = iCont_in;
          end
        end
      end
      REQ: begin
        // An ack in the final allowed cycle still completes the transfer.
        if (dmem_ack || cnt_q == TO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          mis_d   = 1'b0;
          err_d   = ~dmem_ack;
          wb_d    = (dmem_ack && !we_q) ? extractLoad(dmem_rdata, off_q, size_q, uns_q) : 32'd0;
          pcOut_d = pcPend_q;
          icOut_d = icPend_q;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      pcPend_q <= '0;
      icPend_q <= '0;
      wb_q     <= '0;
      pcOut_q  <= '0;
      icOut_q  <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      pcPend_q <= pcPend_d;
      icPend_q <= icPend_d;
      wb_q     <= wb_d;
      pcOut_q  <= pcOut_d;
      icOut_q  <= icOut_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign stall_out  = (state_q == REQ);
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_data    = wb_q;
  assign PC_out     = pcOut_q;
  assign iCont_out  = icOut_q;
  assign misalign   = mis_q;
  assign bus_err    = err_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (built with TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_in;
  logic [31:0] result_in, hold_op2_in, PC_in;
  logic [31:0] iCont_in;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] wb_data, PC_out;
  logic [31:0] iCont_out;
  logic        misalign, bus_err, done_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .ICONT_W(32)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .result_in(result_in),
    .hold_op2_in(hold_op2_in), .iCont_in(iCont_in), .PC_in(PC_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_data(wb_data), .iCont_out(iCont_out), .PC_out(PC_out),
    .misalign(misalign), .bus_err(bus_err), .done_out(done_out)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns, input logic [31:0] d);
    done_in = 1'b1; result_in = addr; mem_read = rd; mem_write = wr;
    mem_size = sz; mem_unsigned = uns; hold_op2_in = d;
    PC_in = addr + 32'h1000; iCont_in = ~addr;
  endtask

  task automatic idleInputs();
    done_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; idleInputs();
    result_in = '0; hold_op2_in = '0; PC_in = '0; iCont_in = '0;
    mem_size = '0; mem_unsigned = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (done_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done_out); end
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b want 0", dmem_req); end
    checks++; if (wb_data !== 32'd0) begin fails++; $display("[TB] FAIL reset_wb got %h want 0", wb_data); end
    checks++; if (iCont_out !== 32'd0) begin fails++; $display("[TB] FAIL reset_icont got %h want 0", iCont_out); end
    checks++; if (stall_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall got %b want 0", stall_out); end
  endtask

  task automatic test_alu_pass();
    issue(32'h0000_002A, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
    tick(); idleInputs();
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL alu_done got %b want 1", done_out); end
    checks++; if (wb_data !== 32'h2A) begin fails++; $display("[TB] FAIL alu_wb got %h want 0000002a", wb_data); end
    checks++; if (PC_out !== 32'h102A) begin fails++; $display("[TB] FAIL alu_pc got %h want 0000102a", PC_out); end
    checks++; if (iCont_out !== 32'hFFFF_FFD5) begin fails++; $display("[TB] FAIL alu_icont got %h want ffffffd5", iCont_out); end
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL alu_req got %b want 0", dmem_req); end
    tick();
    checks++; if (done_out !== 1'b0) begin fails++; $display("[TB] FAIL alu_pulse got %b want 0", done_out); end
    checks++; if (wb_data !== 32'h2A) begin fails++; $display("[TB] FAIL alu_hold got %h want 0000002a", wb_data); end
  endtask

  task automatic test_lw_zero_wait();
    issue(32'h100, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    tick(); idleInputs();
    checks++; if (dmem_req !== 1'b1) begin fails++; $display("[TB] FAIL lw_req got %b want 1", dmem_req); end
    checks++; if (dmem_be !== 4'b1111) begin fails++; $display("[TB] FAIL lw_be got %b want 1111", dmem_be); end
    checks++; if (dmem_addr !== 32'h100) begin fails++; $display("[TB] FAIL lw_addr got %h want 00000100", dmem_addr); end
    checks++; if (dmem_we !== 1'b0) begin fails++; $display("[TB] FAIL lw_we got %b want 0", dmem_we); end
    checks++; if (done_out !== 1'b0) begin fails++; $display("[TB] FAIL lw_early_done got %b want 0", done_out); end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick(); dmem_ack = 1'b0;
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL lw_done got %b want 1", done_out); end
    checks++; if (wb_data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL lw_wb got %h want deadbeef", wb_data); end
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL lw_req_drop got %b want 0", dmem_req); end
    checks++; if (PC_out !== 32'h1100) begin fails++; $display("[TB] FAIL lw_pc got %h want 00001100", PC_out); end
    tick();
  endtask

  task automatic test_lb_wait();
    logic [31:0] expWb [2];
    expWb[0] = 32'hFFFF_FF80;
    expWb[1] = 32'h0000_0080;
    for (int u = 0; u < 2; u++) begin
      int stallCnt;
      stallCnt = 0;
      issue(32'h203, 1'b1, 1'b0, 2'b00, u[0], 32'h0);
      tick(); idleInputs();
      checks++; if (dmem_be !== 4'b1000) begin fails++; $display("[TB] FAIL lb_be[%0d] got %b want 1000", u, dmem_be); end
      checks++; if (dmem_addr !== 32'h200) begin fails++; $display("[TB] FAIL lb_addr[%0d] got %h want 00000200", u, dmem_addr); end
      for (int i = 0; i < 4; i++) begin
        if (stall_out === 1'b1) stallCnt++;
        if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'h8011_2233; end
        tick();
      end
      dmem_ack = 1'b0;
      checks++; if (stallCnt !== 4) begin fails++; $display("[TB] FAIL lb_stall[%0d] got %0d want 4", u, stallCnt); end
      checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL lb_done[%0d] got %b want 1", u, done_out); end
      checks++; if (wb_data !== expWb[u]) begin fails++; $display("[TB] FAIL lb_wb[%0d] got %h want %h", u, wb_data, expWb[u]); end
      checks++; if (bus_err !== 1'b0) begin fails++; $display("[TB] FAIL lb_err[%0d] got %b want 0", u, bus_err); end
      checks++; if (stall_out !== 1'b0) begin fails++; $display("[TB] FAIL lb_stall_end[%0d] got %b want 0", u, stall_out); end
      tick();
    end
  endtask

  task automatic test_sh();
    issue(32'h302, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_ABCD);
    tick(); idleInputs();
    checks++; if (dmem_addr !== 32'h300) begin fails++; $display("[TB] FAIL sh_addr got %h want 00000300", dmem_addr); end
    checks++; if (dmem_be !== 4'b1100) begin fails++; $display("[TB] FAIL sh_be got %b want 1100", dmem_be); end
    checks++; if (dmem_wdata !== 32'hABCD_ABCD) begin fails++; $display("[TB] FAIL sh_wdata got %h want abcdabcd", dmem_wdata); end
    checks++; if (dmem_we !== 1'b1) begin fails++; $display("[TB] FAIL sh_we got %b want 1", dmem_we); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick(); dmem_ack = 1'b0;
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL sh_done got %b want 1", done_out); end
    checks++; if (wb_data !== 32'd0) begin fails++; $display("[TB] FAIL sh_wb got %h want 0", wb_data); end
    tick();
  endtask

  task automatic test_sb_lane();
    issue(32'h501, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1234_56A5);
    tick(); idleInputs();
    checks++; if (dmem_be !== 4'b0010) begin fails++; $display("[TB] FAIL sb_be got %b want 0010", dmem_be); end
    checks++; if (dmem_wdata !== 32'hA5A5_A5A5) begin fails++; $display("[TB] FAIL sb_wdata got %h want a5a5a5a5", dmem_wdata); end
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    issue(32'h101, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    tick(); idleInputs();
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL mis_req got %b want 0", dmem_req); end
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL mis_done got %b want 1", done_out); end
    checks++; if (misalign !== 1'b1) begin fails++; $display("[TB] FAIL mis_flag got %b want 1", misalign); end
    checks++; if (wb_data !== 32'd0) begin fails++; $display("[TB] FAIL mis_wb got %h want 0", wb_data); end
    tick();
  endtask

  task automatic test_timeout();
    int reqCnt;
    reqCnt = 0;
    issue(32'h400, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    tick(); idleInputs();
    for (int i = 0; i < 4; i++) begin
      if (dmem_req === 1'b1) reqCnt++;
      tick();
    end
    checks++; if (reqCnt !== 4) begin fails++; $display("[TB] FAIL to_reqcycles got %0d want 4", reqCnt); end
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL to_req got %b want 0", dmem_req); end
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL to_done got %b want 1", done_out); end
    checks++; if (bus_err !== 1'b1) begin fails++; $display("[TB] FAIL to_err got %b want 1", bus_err); end
    checks++; if (wb_data !== 32'd0) begin fails++; $display("[TB] FAIL to_wb got %h want 0", wb_data); end
    tick();
  endtask

  task automatic test_ack_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    dmem_ack = 1'b0;
    checks++; if (done_out !== 1'b0) begin fails++; $display("[TB] FAIL idle_ack_done got %b want 0", done_out); end
    checks++; if (stall_out !== 1'b0) begin fails++; $display("[TB] FAIL idle_ack_stall got %b want 0", stall_out); end
  endtask

  task automatic test_back_to_back();
    issue(32'h11, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    issue(32'h22, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0);
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL b2b_first got %b want 1", done_out); end
    tick(); idleInputs();
    checks++; if (done_out !== 1'b1) begin fails++; $display("[TB] FAIL b2b_second got %b want 1", done_out); end
    checks++; if (wb_data !== 32'h22) begin fails++; $display("[TB] FAIL b2b_wb got %h want 00000022", wb_data); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    issue(32'h600, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    tick(); idleInputs();
    checks++; if (dmem_req !== 1'b1) begin fails++; $display("[TB] FAIL rmid_req_before got %b want 1", dmem_req); end
    rst = 1'b1;
    tick(); rst = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin fails++; $display("[TB] FAIL rmid_req got %b want 0", dmem_req); end
    checks++; if (done_out !== 1'b0) begin fails++; $display("[TB] FAIL rmid_done got %b want 0", done_out); end
    checks++; if (wb_data !== 32'd0) begin fails++; $display("[TB] FAIL rmid_wb got %h want 0", wb_data); end
    checks++; if (PC_out !== 32'd0) begin fails++; $display("[TB] FAIL rmid_pc got %h want 0", PC_out); end
    checks++; if (dmem_addr !== 32'd0) begin fails++; $display("[TB] FAIL rmid_addr got %h want 0", dmem_addr); end
    tick();
    checks++; if (done_out !== 1'b0) begin fails++; $display("[TB] FAIL rmid_late_done got %b want 0", done_out); end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lw_zero_wait();
    test_lb_wait();
    test_sh();
    test_sb_lane();
    test_misaligned();
    test_timeout();
    test_ack_idle();
    test_back_to_back();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
